// File: rtl/cordic_host_pkg.sv
// Shared constants for the CORDIC chip host driver: pin map and state encoding.
package cordic_host_pkg;

    localparam int PIN_W    = 12;
    localparam int OPND_LSB = 0;
    localparam int OPND_W   = 10;
    localparam int MODE_TGL = 10;
    localparam int OUT_TGL  = 11;
    localparam int VAL_W    = 11;
    localparam int DONE_BIT = 11;

    // State encoding, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_MODE      = 3'd1;
    localparam state_t ST_SETTLE    = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_TOG       = 3'd4;
    localparam state_t ST_GAP       = 3'd5;
    localparam state_t ST_RESTORE   = 3'd6;
    localparam state_t ST_RESP      = 3'd7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cordic_host_timer.sv
// Loadable down-counter with a zero flag; shared by the settle, gap and timeout phases.
module cordic_host_timer #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/cordic_host_driver.sv
// Host-side master for the CORDIC chip pin interface: request in, pin sequencing,
// two-word capture, response out.
module cordic_host_driver
    import cordic_host_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int TOGGLE_GAP    = 2,
    parameter int TIMEOUT       = 1023
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OPND_W-1:0]  req_angle,
    input  logic               req_mode,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [VAL_W-1:0]   rsp_val0,
    output logic [VAL_W-1:0]   rsp_val1,
    output logic               rsp_timeout,
    output logic [PIN_W-1:0]   chip_in,
    input  logic [PIN_W-1:0]   chip_out
);

    localparam int CNT_MAX = max3(SETTLE_CYCLES, TOGGLE_GAP, TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state_q, state_d;
    logic [OPND_W-1:0]   opnd_q, opnd_d;
    logic                mode_tgl_q, mode_tgl_d;
    logic                out_tgl_q, out_tgl_d;
    logic                mode_mirror_q, mode_mirror_d;
    logic [VAL_W-1:0]    rsp_val0_q, rsp_val0_d;
    logic [VAL_W-1:0]    rsp_val1_q, rsp_val1_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [VAL_W-1:0]    val_q;
    logic                done_q;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_load_val;
    logic                tmr_dec;
    logic                tmr_zero;

    cordic_host_timer #(
        .W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Pin-side toggles are decided one state early so they appear registered in their own state.
    always_comb begin
        // NOTE: every next-state signal gets a default here, so no latch is inferred.
        state_d       = state_q;
        opnd_d        = opnd_q;
        mode_tgl_d    = 1'b0;
        out_tgl_d     = 1'b0;
        mode_mirror_d = mode_mirror_q;
        rsp_val0_d    = rsp_val0_q;
        rsp_val1_d    = rsp_val1_q;
        rsp_timeout_d = rsp_timeout_q;
        tmr_load      = 1'b0;
        tmr_load_val  = '0;
        tmr_dec       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    opnd_d        = req_angle;
                    rsp_val0_d    = '0;
                    rsp_val1_d    = '0;
                    rsp_timeout_d = 1'b0;
                    if (req_mode != mode_mirror_q) begin
                        mode_tgl_d    = 1'b1;
                        mode_mirror_d = ~mode_mirror_q;
                    end
                    state_d = ST_MODE;
                end
            end
            ST_MODE: begin
                tmr_load     = 1'b1;
                tmr_load_val = CNT_W'(SETTLE_CYCLES - 1);
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(TIMEOUT - 1);
                    state_d      = ST_WAIT_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (done_q) begin
                    rsp_val0_d = val_q;
                    out_tgl_d  = 1'b1;
                    state_d    = ST_TOG;
                end else if (tmr_zero) begin
                    rsp_timeout_d = 1'b1;
                    rsp_val0_d    = '0;
                    rsp_val1_d    = '0;
                    state_d       = ST_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_TOG: begin
                tmr_load     = 1'b1;
                tmr_load_val = CNT_W'(TOGGLE_GAP - 1);
                state_d      = ST_GAP;
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    rsp_val1_d = val_q;
                    out_tgl_d  = 1'b1;
                    state_d    = ST_RESTORE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RESTORE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            opnd_q        <= '0;
            mode_tgl_q    <= 1'b0;
            out_tgl_q     <= 1'b0;
            mode_mirror_q <= 1'b0;
            rsp_val0_q    <= '0;
            rsp_val1_q    <= '0;
            rsp_timeout_q <= 1'b0;
            val_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            opnd_q        <= opnd_d;
            mode_tgl_q    <= mode_tgl_d;
            out_tgl_q     <= out_tgl_d;
            mode_mirror_q <= mode_mirror_d;
            rsp_val0_q    <= rsp_val0_d;
            rsp_val1_q    <= rsp_val1_d;
            rsp_timeout_q <= rsp_timeout_d;
            val_q         <= chip_out[VAL_W-1:0];
            done_q        <= chip_out[DONE_BIT];
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_val0    = rsp_val0_q;
    assign rsp_val1    = rsp_val1_q;
    assign rsp_timeout = rsp_timeout_q;

    assign chip_in[OPND_LSB +: OPND_W] = opnd_q;
    assign chip_in[MODE_TGL]           = mode_tgl_q;
    assign chip_in[OUT_TGL]            = out_tgl_q;

endmodule

// File: tb/tb_cordic_host_driver.sv
// Directed bench for cordic_host_driver with a registered CORDIC chip pin model
// and a scoreboard of expected responses.
module tb_cordic_host_driver;

    localparam int S   = 4;
    localparam int TG  = 2;
    localparam int TMO = 16;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_angle;
    logic        req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [10:0] rsp_val0;
    logic [10:0] rsp_val1;
    logic        rsp_timeout;
    logic [11:0] chip_in;
    logic [11:0] chip_out;

    cordic_host_driver #(
        .SETTLE_CYCLES (S),
        .TOGGLE_GAP    (TG),
        .TIMEOUT       (TMO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_angle   (req_angle),
        .req_mode    (req_mode),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_val0    (rsp_val0),
        .rsp_val1    (rsp_val1),
        .rsp_timeout (rsp_timeout),
        .chip_in     (chip_in),
        .chip_out    (chip_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Chip model: mode and output select flip on toggle pulses; done rises done_dly cycles after load.
    logic [10:0] va = 11'h0;
    logic [10:0] vb = 11'h0;
    logic [10:0] stale_val = 11'h0;
    int          done_dly = 6;
    int          stale_len = 0;
    logic        done_en = 1'b1;
    logic        chip_mode;
    logic        chip_sel;
    int          since_load;

    always @(posedge clock) begin
        if (!reset_n) begin
            chip_mode  <= 1'b0;
            chip_sel   <= 1'b0;
            since_load <= 1000;
        end else begin
            if (chip_in[10]) chip_mode <= ~chip_mode;
            if (chip_in[11]) chip_sel <= ~chip_sel;
            if (req_valid && req_ready) since_load <= 0;
            else if (since_load < 1000) since_load <= since_load + 1;
        end
    end

    assign chip_out[11]   = (done_en && (since_load >= done_dly)) || (since_load < stale_len);
    assign chip_out[10:0] = (since_load < stale_len) ? stale_val : (chip_sel ? vb : va);

    // Pulse monitor on the toggle pins.
    int   mode_pulses = 0;
    int   out_pulses = 0;
    int   overlap = 0;
    int   wide = 0;
    logic prev_mt = 1'b0;
    logic prev_ot = 1'b0;

    always @(posedge clock) begin
        if (chip_in[10] === 1'b1) mode_pulses++;
        if (chip_in[11] === 1'b1) out_pulses++;
        if (chip_in[10] === 1'b1 && chip_in[11] === 1'b1) overlap++;
        if (chip_in[10] === 1'b1 && prev_mt) wide++;
        if (chip_in[11] === 1'b1 && prev_ot) wide++;
        prev_mt = (chip_in[10] === 1'b1);
        prev_ot = (chip_in[11] === 1'b1);
    end

    typedef struct {
        logic [10:0] v0;
        logic [10:0] v1;
        logic        tmo;
        int          lat;
        int          mode_d;
        int          out_d;
        logic [9:0]  angle;
        logic        mode;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   acc_neg = 0;
    int   mp_base = 0;
    int   op_base = 0;
    logic exp_mirror = 1'b0;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [9:0] angle, input logic mode);
        exp_t e;
        e.angle  = angle;
        e.mode   = mode;
        e.tmo    = !done_en;
        e.v0     = done_en ? va : 11'h0;
        e.v1     = done_en ? vb : 11'h0;
        e.lat    = done_en ? (5 + done_dly + TG) : (2 + S + TMO);
        e.mode_d = (mode != exp_mirror) ? 1 : 0;
        e.out_d  = done_en ? 2 : 0;
        exp_mirror = mode;
        sb.push_back(e);
        mp_base = mode_pulses;
        op_base = out_pulses;
    endtask

    task automatic send_req(input logic [9:0] angle, input logic mode);
        for (int i = 0; i < 50 && req_ready !== 1'b1; i++) tick();
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_angle = angle;
        req_mode  = mode;
        push_exp(angle, mode);
        acc_neg = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int hold, input bit handshake);
        exp_t e;
        bit   stable;
        for (int i = 0; i < 200 && rsp_valid !== 1'b1; i++) tick();
        check("rsp_wait", {31'd0, rsp_valid}, 32'd1);
        e = sb.pop_front();
        check("latency", cyc - acc_neg, e.lat);
        check("val0", {21'd0, rsp_val0}, {21'd0, e.v0});
        check("val1", {21'd0, rsp_val1}, {21'd0, e.v1});
        check("timeout_flag", {31'd0, rsp_timeout}, {31'd0, e.tmo});
        check("opnd_held", {22'd0, chip_in[9:0]}, {22'd0, e.angle});
        check("mode_pulses", mode_pulses - mp_base, e.mode_d);
        check("out_pulses", out_pulses - op_base, e.out_d);
        check("chip_mode", {31'd0, chip_mode}, {31'd0, e.mode});
        check("chip_sel_restored", {31'd0, chip_sel}, 32'd0);
        stable = 1'b1;
        if (hold > 0) begin
            req_valid = 1'b1;
            req_angle = 10'h3FF;
            req_mode  = ~e.mode;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_val0 !== e.v0 ||
                rsp_val1 !== e.v1 || rsp_timeout !== e.tmo || chip_in[9:0] !== e.angle)
                stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", {31'd0, stable}, 32'd1);
        if (handshake) begin
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_angle = 10'h0;
        req_mode  = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_chip_in", {20'd0, chip_in}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_val0", {21'd0, rsp_val0}, 32'd0);
        check("rst_val1", {21'd0, rsp_val1}, 32'd0);
        check("rst_timeout", {31'd0, rsp_timeout}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic transaction, default mode.
        va = 11'h2AA; vb = 11'h0F0; done_dly = 6; stale_len = 0; done_en = 1'b1;
        send_req(10'h155, 1'b0);
        wait_rsp(0, 1'b1);

        // Mode changes: pulse, no pulse, pulse.
        va = 11'h123; vb = 11'h456; done_dly = 7;
        send_req(10'h0AB, 1'b1);
        wait_rsp(0, 1'b1);
        va = 11'h7FE; vb = 11'h001; done_dly = 4;
        send_req(10'h3C0, 1'b1);
        wait_rsp(0, 1'b1);
        va = 11'h555; vb = 11'h2AB; done_dly = 9;
        send_req(10'h001, 1'b0);
        wait_rsp(0, 1'b1);

        // Backpressure, then a request accepted the cycle after the handshake.
        va = 11'h0C3; vb = 11'h73C; done_dly = 6;
        send_req(10'h2F0, 1'b0);
        wait_rsp(20, 1'b0);
        rsp_ready = 1'b1;
        va = 11'h6A6; vb = 11'h159; done_dly = 5;
        req_valid = 1'b1; req_angle = 10'h19B; req_mode = 1'b1;
        push_exp(10'h19B, 1'b1);
        tick();
        check("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
        acc_neg = cyc;
        tick();
        req_valid = 1'b0;
        check("b2b_accepted", {31'd0, req_ready}, 32'd0);
        wait_rsp(0, 1'b1);

        // Timeout: done never rises.
        va = 11'h3FF; vb = 11'h7FF; done_en = 1'b0;
        send_req(10'h222, 1'b0);
        wait_rsp(0, 1'b1);
        done_en = 1'b1;

        // Stale done held for two cycles after load.
        va = 11'h246; vb = 11'h135; stale_val = 11'h7FF; stale_len = 2; done_dly = 6;
        send_req(10'h0F0, 1'b0);
        wait_rsp(0, 1'b1);
        stale_len = 0;

        // Reset dropped during the gap phase.
        va = 11'h3C3; vb = 11'h03C; done_dly = 6;
        send_req(10'h1A5, 1'b1);
        while (cyc < acc_neg + 10) tick();
        check("pre_rst_val0", {21'd0, rsp_val0}, 32'h3C3);
        reset_n = 1'b0;
        tick();
        check("mid_rst_chip_in", {20'd0, chip_in}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_val0", {21'd0, rsp_val0}, 32'd0);
        check("mid_rst_val1", {21'd0, rsp_val1}, 32'd0);
        check("mid_rst_mirror", {31'd0, dut.mode_mirror_q}, 32'd0);
        reset_n = 1'b1;
        sb.delete();
        exp_mirror = 1'b0;
        tick();

        // After reset the mirror is 0 again, so mode=1 must pulse.
        va = 11'h5A5; vb = 11'h25A; done_dly = 5;
        send_req(10'h2AA, 1'b1);
        wait_rsp(0, 1'b1);

        check("toggle_overlap", overlap, 32'd0);
        check("toggle_width", wide, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_host_driver.md
# cordic_host_driver

Host-side master for the CORDIC chip's 12-bit pin interface. It accepts a request (angle and mode) on a valid/ready port, drives the chip's input pins, and pulses the mode and output-select toggles as needed. It waits for `done`, captures both result words, and returns them on a valid/ready response port. It sits in the FPGA/bench harness, directly opposite the chip pins.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles the operand is held after load before `done` is sampled. This masks a stale `done`.
- `TOGGLE_GAP`, default 2: cycles between the `out_toggle` pulse and capture of the second word.
- `TIMEOUT`, default 1023: maximum number of `WAIT_DONE` cycles before the request is aborted.

Ports:
- `clock` in 1: single clock. All logic is on its rising edge.
- `reset_n` in 1: synchronous reset, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in `IDLE`.
- `req_angle` in 10: operand for chip pins [9:0].
- `req_mode` in 1: requested chip compute mode.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response accepted.
- `rsp_val0` out 11: first result word (default output select).
- `rsp_val1` out 11: second result word (after `out_toggle`).
- `rsp_timeout` out 1: request aborted. Both words are 0 when set.
- `chip_in` out 12: to chip. Bits [9:0] are the operand, bit [10] is `mode_toggle`, bit [11] is `out_toggle`.
- `chip_out` in 12: from chip. Bits [10:0] are `val`, bit [11] is `done`.

## Operation
- `chip_out` is registered once (`val_q`, `done_q`). All decisions use the registered copies.
- `chip_in` is fully registered, with no combinational path from the inputs.
- `mode_mirror` tracks the chip's mode. It resets to 0, matching the chip's reset state. It flips on every `mode_toggle` pulse.

State machine:
- **`IDLE`:** `req_ready`=1. On `req_valid`, latch the angle and mode, drive the angle onto `chip_in[9:0]`, and go to `MODE`.
- **`MODE`:** one cycle. If `req_mode` differs from `mode_mirror`, drive `mode_toggle`=1 for this cycle and flip the mirror. Go to `SETTLE`.
- **`SETTLE`:** lasts `SETTLE_CYCLES` cycles, then go to `WAIT_DONE`.
- **`WAIT_DONE`:**
  - If `done_q`=1, capture `val_q` into `rsp_val0` and go to `TOG`.
  - If the counter reaches `TIMEOUT`, set `rsp_timeout`=1, zero both words, and go to `RESP`. The toggle sequence is skipped.
- **`TOG`:** `out_toggle`=1 for one cycle, then go to `GAP`.
- **`GAP`:** lasts `TOGGLE_GAP` cycles. On the last cycle, capture `val_q` into `rsp_val1`. Go to `RESTORE`.
- **`RESTORE`:** `out_toggle`=1 for one cycle, which returns the chip to the default output select. Go to `RESP`.
- **`RESP`:** `rsp_valid`=1. Outputs are held stable until `rsp_ready`, then go to `IDLE`.

Pin and port rules:
- The operand on `chip_in[9:0]` is held from `MODE` through `RESP`.
- Toggle bits are 0 outside their pulse cycles.
- Toggle pulses are exactly one cycle wide and never simultaneous.
- There are no arithmetic transforms: values pass through bit-exact.
- `req_ready` and `rsp_valid` are never high together, so a new request is accepted no earlier than the cycle after the response handshake.
- Changes to `req_*` while not in `IDLE` are ignored.

## Timing
- Reset values:
  - All `chip_in` bits = 0.
  - `req_ready`=1 on the first cycle after reset.
  - `rsp_valid`=0, `rsp_val0`=0, `rsp_val1`=0, `rsp_timeout`=0.
  - `mode_mirror`=0, state=`IDLE`.
- Let cycle A be the cycle the request is accepted. From A+1, `chip_in[9:0]` = angle and `mode_toggle` is pulsed if needed.
- `done_q` is first examined at A+2+`SETTLE_CYCLES`.
- If `done` rises at pin cycle D, capture happens at D+1. `out_toggle` pulses at D+2. `val1` is captured at D+2+`TOGGLE_GAP`. The restore pulse follows, and `rsp_valid` rises at D+4+`TOGGLE_GAP`.
- Timeout: `rsp_valid` rises `TIMEOUT` cycles after `WAIT_DONE` is entered, if `done_q` never went high.
- Reset mid-operation: all outputs return to their reset values on the next edge. Any captured data is discarded. The bench must also reset the chip so the mode mirror stays consistent.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide. It is cleared on entry to `WAIT_DONE`.

## Structure
- Package `cordic_host_pkg` holds:
  - the state enum;
  - pin index constants: `OPND_LSB`=0, `OPND_W`=10, `MODE_TGL`=10, `OUT_TGL`=11, `VAL_W`=11, `DONE_BIT`=11.
- Sub-module `cordic_host_timer`: a loadable down-counter with a `zero` flag, shared by the `SETTLE`, `GAP` and timeout phases.

## Test plan
- **Basic:** angle=10'h155, mode=0, chip model raises `done` 6 cycles after load with `val`=11'h2AA and toggled `val`=11'h0F0 → `rsp_val0`=0x2AA, `rsp_val1`=0x0F0, no `mode_toggle` pulse, exactly two `out_toggle` pulses.
- **Mode change:** request with mode=1, then with mode=1 again → one `mode_toggle` pulse on the first request only. A third request with mode=0 pulses it again.
- **Backpressure:** hold `rsp_ready`=0 for 20 cycles → response words stable, `req_ready`=0 throughout. A new request is accepted on the cycle after the handshake.
- **Timeout:** with `TIMEOUT`=16, keep `done` low → `rsp_timeout`=1, both words 0, no `out_toggle` pulses, `rsp_valid` 16 cycles after entering `WAIT_DONE`.
- **Stale `done`:** chip holds `done`=1 for 2 cycles after a new load → the driver must not capture before `SETTLE` expires.
- **Reset mid-operation:** drop `reset_n` during `GAP` → on the next cycle `chip_in`=0, `rsp_valid`=0, state=`IDLE`, `mode_mirror`=0.
